// File: rtl/fft4_input_loader_pkg.sv
// Shared definitions for the 4-point FFT input path: widths, frame geometry,
// the complex sample type and the ping-pong bank selector.
package fft4_input_loader_pkg;

  localparam int DEF_DW = 32;
  localparam int N      = 4;
  localparam int IDX_W  = 2;

  localparam logic [IDX_W-1:0] FIRST_IDX = 2'd0;
  localparam logic [IDX_W-1:0] LAST_IDX  = 2'd3;

  typedef struct packed {
    logic signed [DEF_DW-1:0] re;
    logic signed [DEF_DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  // Ping-pong partner of a bank.
  function automatic bank_e other_bank(input bank_e b);
    case (b)
      BANK_A:  return BANK_B;
      BANK_B:  return BANK_A;
      default: return BANK_A;
    endcase
  endfunction

endpackage

// File: rtl/fft4_input_loader_if.sv
// Bus bundle of the FFT input loader: serial sample side and parallel frame side.
interface fft4_input_loader_if
  import fft4_input_loader_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = 16
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sof;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x0_re, x0_im, x1_re, x1_im;
  logic signed [DW-1:0] x2_re, x2_im, x3_re, x3_im;
  logic                 frame_err;
  logic [CW-1:0]        frame_cnt;

  // Loader side.
  modport slave (
    input  in_valid, in_sof, in_re, in_im, out_ready,
    output in_ready, out_valid,
    output x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
    output frame_err, frame_cnt
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_sof, in_re, in_im, out_ready,
    input  in_ready, out_valid,
    input  x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
    input  frame_err, frame_cnt
  );

endinterface

// File: rtl/fft4_frame_bank.sv
// Four-entry complex register file: one indexed write port, full parallel read.
module fft4_frame_bank
  import fft4_input_loader_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     widx,
  input  logic signed [DW-1:0] wre,
  input  logic signed [DW-1:0] wim,
  output logic signed [DW-1:0] rd_re [N],
  output logic signed [DW-1:0] rd_im [N]
);

  logic signed [DW-1:0] mem_re_r [N];
  logic signed [DW-1:0] mem_im_r [N];

  // Sample storage; only the addressed entry changes on a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_re_r[i] <= '0;
        mem_im_r[i] <= '0;
      end
    end else if (we) begin
      mem_re_r[widx] <= wre;
      mem_im_r[widx] <= wim;
    end else begin
      mem_re_r <= mem_re_r;
      mem_im_r <= mem_im_r;
    end
  end

  // Whole frame is always visible for a single-cycle parallel copy.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rd_re[i] = mem_re_r[i];
      rd_im[i] = mem_im_r[i];
    end
  end

endmodule

// File: rtl/fft4_input_loader.sv
// Serial-to-parallel frame loader for the 4-point FFT core. Samples are
// collected into one of two ping-pong banks; completed banks are copied into
// an output register set under a valid/ready handshake.
module fft4_input_loader
  import fft4_input_loader_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = 16
) (
  input  logic               clk,
  input  logic               rst,
  fft4_input_loader_if.slave bus
);

  logic [IDX_W-1:0]     idx_r;
  bank_e                wr_bank_r;
  bank_e                rd_bank_r;
  logic [1:0]           full_r;
  logic                 out_valid_r;
  logic signed [DW-1:0] x_re_r [N];
  logic signed [DW-1:0] x_im_r [N];
  logic                 frame_err_r;
  logic [CW-1:0]        frame_cnt_r;

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 complete_s;
  logic                 load_s;
  logic [IDX_W-1:0]     wr_idx_s;
  logic [1:0]           we_s;
  logic [1:0]           full_next_s;
  logic signed [DW-1:0] a_re_s [N];
  logic signed [DW-1:0] a_im_s [N];
  logic signed [DW-1:0] b_re_s [N];
  logic signed [DW-1:0] b_im_s [N];
  logic signed [DW-1:0] sel_re_s [N];
  logic signed [DW-1:0] sel_im_s [N];

  // Handshake decode. in_ready depends on buffer state only, never on in_valid.
  always_comb begin
    in_ready_s  = !full_r[wr_bank_r];
    accept_s    = bus.in_valid && in_ready_s;
    complete_s  = accept_s && !bus.in_sof && (idx_r == LAST_IDX);
    load_s      = (!out_valid_r || bus.out_ready) && full_r[rd_bank_r];
    if (bus.in_sof) begin
      wr_idx_s = FIRST_IDX;
    end else begin
      wr_idx_s = idx_r;
    end
    we_s[0] = accept_s && (wr_bank_r == BANK_A);
    we_s[1] = accept_s && (wr_bank_r == BANK_B);
  end

  // Full flags: the drained bank and the filled bank are never the same one.
  always_comb begin
    full_next_s = full_r;
    if (load_s) begin
      full_next_s[rd_bank_r] = 1'b0;
    end else begin
      full_next_s = full_next_s;
    end
    if (complete_s) begin
      full_next_s[wr_bank_r] = 1'b1;
    end else begin
      full_next_s = full_next_s;
    end
  end

  // Select the bank being drained into the output registers.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (rd_bank_r == BANK_A) begin
        sel_re_s[i] = a_re_s[i];
        sel_im_s[i] = a_im_s[i];
      end else begin
        sel_re_s[i] = b_re_s[i];
        sel_im_s[i] = b_im_s[i];
      end
    end
  end

  fft4_frame_bank #(.DW(DW)) u_bank_a (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s[0]),
    .widx  (wr_idx_s),
    .wre   (bus.in_re),
    .wim   (bus.in_im),
    .rd_re (a_re_s),
    .rd_im (a_im_s)
  );

  fft4_frame_bank #(.DW(DW)) u_bank_b (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s[1]),
    .widx  (wr_idx_s),
    .wre   (bus.in_re),
    .wim   (bus.in_im),
    .rd_re (b_re_s),
    .rd_im (b_im_s)
  );

  // Write side: sample index, bank toggle, sticky error on a restarted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= FIRST_IDX;
      wr_bank_r   <= BANK_A;
      full_r      <= 2'b00;
      frame_err_r <= 1'b0;
    end else begin
      full_r <= full_next_s;
      if (accept_s && bus.in_sof) begin
        idx_r       <= 2'd1;
        frame_err_r <= frame_err_r | (idx_r != FIRST_IDX);
      end else if (accept_s && (idx_r == LAST_IDX)) begin
        idx_r     <= FIRST_IDX;
        wr_bank_r <= other_bank(wr_bank_r);
      end else if (accept_s) begin
        idx_r <= idx_r + 2'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Output stage: load a full bank when free or being consumed, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_r   <= BANK_A;
      out_valid_r <= 1'b0;
      frame_cnt_r <= '0;
      for (int i = 0; i < N; i++) begin
        x_re_r[i] <= '0;
        x_im_r[i] <= '0;
      end
    end else if (load_s) begin
      rd_bank_r   <= other_bank(rd_bank_r);
      out_valid_r <= 1'b1;
      frame_cnt_r <= frame_cnt_r + CW'(1);
      for (int i = 0; i < N; i++) begin
        x_re_r[i] <= sel_re_s[i];
        x_im_r[i] <= sel_im_s[i];
      end
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.frame_cnt = frame_cnt_r;
  assign bus.x0_re     = x_re_r[0];
  assign bus.x0_im     = x_im_r[0];
  assign bus.x1_re     = x_re_r[1];
  assign bus.x1_im     = x_im_r[1];
  assign bus.x2_re     = x_re_r[2];
  assign bus.x2_im     = x_im_r[2];
  assign bus.x3_re     = x_re_r[3];
  assign bus.x3_im     = x_im_r[3];

endmodule

// File: tb/tb_fft4_input_loader.sv
// Bench for fft4_input_loader: directed scenarios plus random traffic, all
// checked each cycle against a queue-based frame model.
module tb_fft4_input_loader;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef logic [2*DW-1:0] samp_t;
  typedef logic [4*2*DW-1:0] frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int timeouts    = 0;
  int pin_id      = 0;

  // model state
  frame_t        pend_q[$];
  samp_t         part_q[$];
  frame_t        m_x;
  bit            m_ov;
  bit            m_err;
  logic [CW-1:0] m_cnt;

  always #5 clk = ~clk;

  fft4_input_loader_if #(.DW(DW), .CW(CW)) bus ();

  fft4_input_loader #(.DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic frame_t fr4(input int r0, input int r1, input int r2, input int r3);
    fr4 = {DW'(r3), DW'(-r3), DW'(r2), DW'(-r2), DW'(r1), DW'(-r1), DW'(r0), DW'(-r0)};
  endfunction

  function automatic frame_t dut_frame();
    dut_frame = {bus.x3_re, bus.x3_im, bus.x2_re, bus.x2_im,
                 bus.x1_re, bus.x1_im, bus.x0_re, bus.x0_im};
  endfunction

  task automatic m_reset();
    pend_q.delete();
    part_q.delete();
    m_x   = '0;
    m_ov  = 1'b0;
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  // Frame-level behaviour: up to two completed frames wait behind the output register.
  task automatic m_step();
    bit acc, ld;
    acc = bus.in_valid && (pend_q.size() < 2);
    ld  = (!m_ov || bus.out_ready) && (pend_q.size() > 0);
    if (ld) begin
      m_x   = pend_q.pop_front();
      m_ov  = 1'b1;
      m_cnt = m_cnt + 1'b1;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
    if (acc) begin
      if (bus.in_sof) begin
        if (part_q.size() != 0) m_err = 1'b1;
        part_q.delete();
      end
      part_q.push_back({bus.in_re, bus.in_im});
      if (part_q.size() == 4) begin
        pend_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
        part_q.delete();
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Compare process: every field every cycle, plus literal pins on request.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready",  256'(bus.in_ready),  256'(pend_q.size() < 2));
      chk("out_valid", 256'(bus.out_valid), 256'(m_ov));
      chk("frame_err", 256'(bus.frame_err), 256'(m_err));
      chk("frame_cnt", 256'(bus.frame_cnt), 256'(m_cnt));
      chk("frame",     256'(dut_frame()),   256'(m_x));
      chk("timeout",   256'(timeouts),      256'(0));
      case (pin_id)
        1: begin
          chk("p1_model", 256'(m_x), 256'(fr4(1, 2, 3, 4)));
          chk("p1_frame", 256'(dut_frame()), 256'(fr4(1, 2, 3, 4)));
          chk("p1_ov", 256'(bus.out_valid), 256'(1));
          chk("p1_cnt", 256'(bus.frame_cnt), 256'(1));
          chk("p1_err", 256'(bus.frame_err), 256'(0));
        end
        2: begin
          chk("p2_model", 256'(m_x), 256'(fr4(113, 114, 115, 116)));
          chk("p2_frame", 256'(dut_frame()), 256'(fr4(113, 114, 115, 116)));
          chk("p2_cnt", 256'(bus.frame_cnt), 256'(4));
        end
        3: begin
          chk("p3_frame", 256'(dut_frame()), 256'(fr4(165, 166, 167, 168)));
          chk("p3_cnt_wrap", 256'(bus.frame_cnt), 256'(1));
        end
        4: begin
          chk("p4_in_ready", 256'(bus.in_ready), 256'(0));
          chk("p4_ov", 256'(bus.out_valid), 256'(1));
          chk("p4_frame", 256'(dut_frame()), 256'(fr4(201, 202, 203, 204)));
          chk("p4_cnt", 256'(bus.frame_cnt), 256'(1));
        end
        5: begin
          chk("p5_frame", 256'(dut_frame()), 256'(fr4(209, 210, 211, 212)));
          chk("p5_cnt", 256'(bus.frame_cnt), 256'(3));
          chk("p5_in_ready", 256'(bus.in_ready), 256'(1));
        end
        6: begin
          chk("p6_err", 256'(bus.frame_err), 256'(1));
          chk("p6_frame", 256'(dut_frame()), 256'(fr4(20, 21, 22, 23)));
          chk("p6_cnt", 256'(bus.frame_cnt), 256'(1));
        end
        7: begin
          chk("p7_frame", 256'(dut_frame()), 256'(fr4(5, 6, 7, 8)));
          chk("p7_cnt", 256'(bus.frame_cnt), 256'(1));
          chk("p7_err", 256'(bus.frame_err), 256'(0));
          chk("p7_ov", 256'(bus.out_valid), 256'(1));
        end
        8: chk("p8_ov_low", 256'(bus.out_valid), 256'(0));
        default: ;
      endcase
    end
  end

  // One clock of stimulus; returns just after the following falling edge.
  task automatic cyc(input bit v, input bit sof, input int re, input int im, input bit ordy);
    bus.in_valid  = v;
    bus.in_sof    = sof;
    bus.in_re     = DW'(re);
    bus.in_im     = DW'(im);
    bus.out_ready = ordy;
    @(negedge clk);
    #1;
  endtask

  // Present sample (k, -k) until accepted, bounded.
  task automatic send(input int k, input bit sof);
    bit rdy;
    for (int t = 0; t < 64; t++) begin
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      bus.in_re    = DW'(k);
      bus.in_im    = DW'(-k);
      rdy = bus.in_ready;
      @(negedge clk);
      #1;
      if (rdy) return;
    end
    timeouts++;
    $display("FAIL send_timeout: sample %0d not accepted within 64 cycles", k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    do_reset();

    // basic frame 1..4
    for (int k = 1; k <= 4; k++) send(k, k == 1);
    pin_id = 1; cyc(1'b0, 1'b0, 0, 0, 1'b1); pin_id = 0;

    // continuous stream, 17 frames (frame counter wraps at 16)
    do_reset();
    for (int k = 101; k <= 116; k++) cyc(1'b1, 1'b0, k, -k, 1'b1);
    pin_id = 2; cyc(1'b0, 1'b0, 0, 0, 1'b1); pin_id = 0;
    for (int k = 117; k <= 168; k++) cyc(1'b1, 1'b0, k, -k, 1'b1);
    pin_id = 3; cyc(1'b0, 1'b0, 0, 0, 1'b1); pin_id = 0;

    // backpressure: 12 accepted then stall
    do_reset();
    for (int k = 201; k <= 216; k++) begin
      if (k == 216) pin_id = 4;
      cyc(1'b1, 1'b0, k, -k, 1'b0);
    end
    pin_id = 0;
    cyc(1'b0, 1'b0, 0, 0, 1'b1);
    pin_id = 5; cyc(1'b0, 1'b0, 0, 0, 1'b1); pin_id = 0;
    cyc(1'b0, 1'b0, 0, 0, 1'b1);

    // restarted frame
    do_reset();
    send(10, 1'b1);
    send(11, 1'b0);
    send(20, 1'b1);
    for (int k = 21; k <= 23; k++) send(k, 1'b0);
    pin_id = 6; cyc(1'b0, 1'b0, 0, 0, 1'b1); pin_id = 0;

    // reset mid-frame
    send(30, 1'b1);
    send(31, 1'b0);
    do_reset();
    for (int k = 5; k <= 7; k++) send(k, k == 5);
    pin_id = 8; send(8, 1'b0); pin_id = 0;
    pin_id = 7; cyc(1'b0, 1'b0, 0, 0, 1'b1); pin_id = 0;

    // random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            int'($urandom), int'($urandom), $urandom_range(0, 4) < 3);
      end
    end
    cyc(1'b0, 1'b0, 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
